fatorador_top: RTL and testbench

FATORADOR_TOP -- requirements
Module: fatorador_top

---
 rtl/fatorador_top.sv | 172 +++++++++++++++++
 tb/tb_fatorador_top.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fatorador_top.sv
// Distinct prime factorizer with four 2-digit seven-segment slots.
// Ports: clock, reset_n (sync, active-low), value[15:0] in; hex0..hex7[6:0] out.
module fatorador_top (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] value,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [6:0]  hex6,
  output logic [6:0]  hex7
);

  typedef enum logic [1:0] {
    LOAD,
    DIVIDE,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [15:0] value_q;
  logic [15:0] n;
  logic [8:0]  d;
  logic [2:0]  count;
  logic [15:0] last;
  logic [15:0] work [4];
  logic [15:0] fout [4];

  logic        changed;
  logic [17:0] sq;
  logic [15:0] rem;
  logic [15:0] quo;
  logic        rec;
  logic [15:0] rec_val;
  logic [15:0] n_next;
  logic [8:0]  d_next;

  assign changed = (value != value_q);
  assign sq      = {9'd0, d} * {9'd0, d};
  assign rem     = n % {7'd0, d};
  assign quo     = n / {7'd0, d};

  always_comb begin
    state_next = state;
    rec        = 1'b0;
    rec_val    = n;
    n_next     = n;
    d_next     = d;
    unique case (state)
      LOAD: state_next = DIVIDE;
      DIVIDE: begin
        if (n <= 16'd1) begin
          state_next = DONE;
        end else if (sq > {2'd0, n}) begin
          rec        = 1'b1;
          rec_val    = n;
          state_next = DONE;
        end else if (rem == 16'd0) begin
          rec     = 1'b1;
          rec_val = {7'd0, d};
          n_next  = quo;
        end else begin
          d_next = d + 9'd1;
        end
      end
      DONE: state_next = DONE;
      default: state_next = LOAD;
    endcase
    // A new input always restarts, whatever the FSM was doing.
    if (changed) state_next = LOAD;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= LOAD;
      value_q <= 16'd0;
      n       <= 16'd0;
      d       <= 9'd2;
      count   <= 3'd0;
      last    <= 16'd0;
      for (int i = 0; i < 4; i++) begin
        work[i] <= 16'd0;
        fout[i] <= 16'd0;
      end
    end else begin
      state <= state_next;
      if (changed) value_q <= value;
      if (state == LOAD) begin
        n     <= value;
        d     <= 9'd2;
        count <= 3'd0;
        last  <= 16'd0;
        for (int i = 0; i < 4; i++) work[i] <= 16'd0;
      end else begin
        n <= n_next;
        d <= d_next;
        if (rec && rec_val != last
            && count < 3'd4) begin
          work[count[1:0]] <= rec_val;
          count            <= count + 3'd1;
          last             <= rec_val;
        end
      end
      if (state == DONE) begin
        for (int i = 0; i < 4; i++) fout[i] <= work[i];
      end
    end
  end

  function automatic logic [6:0] seg(
    input logic [3:0] v
  );
    logic [6:0] s;
    unique case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Factor 0 marks an empty slot: shown as "8 8".
  function automatic logic [13:0] slot_hex(
    input logic [15:0] f
  );
    logic [15:0] t;
    logic [15:0] u;
    t = f / 16'd10;
    u = f % 16'd10;
    if (f == 16'd0)
      return 14'd0;
    else if (f > 16'd99)
      return {2{7'b0111111}};
    else
      return {seg(t[3:0]), seg(u[3:0])};
  endfunction

  logic [13:0] s0, s1, s2, s3;

  assign s0 = slot_hex(fout[0]);
  assign s1 = slot_hex(fout[1]);
  assign s2 = slot_hex(fout[2]);
  assign s3 = slot_hex(fout[3]);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      {hex1, hex0} <= 14'd0;
      {hex3, hex2} <= 14'd0;
      {hex5, hex4} <= 14'd0;
      {hex7, hex6} <= 14'd0;
    end else begin
      {hex1, hex0} <= s0;
      {hex3, hex2} <= s1;
      {hex5, hex4} <= s2;
      {hex7, hex6} <= s3;
    end
  end

endmodule

// File: tb/tb_fatorador_top.sv
// Bench for fatorador_top: directed cases plus random values
// checked against an arithmetic prime-factor model.
module tb_fatorador_top;

  logic        clock;
  logic        reset_n;
  logic [15:0] value;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic [6:0]  hex4, hex5, hex6, hex7;

  int checks;
  int errors;

  fatorador_top dut (
    .clock   (clock),
    .reset_n (reset_n),
    .value   (value),
    .hex0    (hex0),
    .hex1    (hex1),
    .hex2    (hex2),
    .hex3    (hex3),
    .hex4    (hex4),
    .hex5    (hex5),
    .hex6    (hex6),
    .hex7    (hex7)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  logic [6:0] digit [10];

  initial begin
    digit[0] = 7'b1000000;
    digit[1] = 7'b1111001;
    digit[2] = 7'b0100100;
    digit[3] = 7'b0110000;
    digit[4] = 7'b0011001;
    digit[5] = 7'b0010010;
    digit[6] = 7'b0000010;
    digit[7] = 7'b1111000;
    digit[8] = 7'b0000000;
    digit[9] = 7'b0010000;
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask

  // Distinct primes of v, ascending, with plain trial division.
  function automatic void primes_of(
    input int v, output int p [4], output int cnt
  );
    int m;
    int q;
    m   = v;
    cnt = 0;
    for (int i = 0; i < 4; i++) p[i] = 0;
    if (m < 2) return;
    q = 2;
    while (q * q <= m) begin
      if (m % q == 0) begin
        if (cnt < 4) p[cnt] = q;
        cnt++;
        while (m % q == 0) m = m / q;
      end
      q++;
    end
    if (m > 1) begin
      if (cnt < 4) p[cnt] = m;
      cnt++;
    end
  endfunction

  function automatic logic [13:0] want_slot(input int f);
    if (f == 0) return 14'd0;
    if (f > 99) return {2{7'b0111111}};
    return {digit[f / 10], digit[f % 10]};
  endfunction

  function automatic logic [13:0] got_slot(input int k);
    case (k)
      0:       return {hex1, hex0};
      1:       return {hex3, hex2};
      2:       return {hex5, hex4};
      default: return {hex7, hex6};
    endcase
  endfunction

  function automatic logic [55:0] want_all(input int v);
    int p [4];
    int c;
    primes_of(v, p, c);
    return {want_slot(p[3]), want_slot(p[2]),
            want_slot(p[1]), want_slot(p[0])};
  endfunction

  function automatic logic [55:0] got_all();
    return {got_slot(3), got_slot(2),
            got_slot(1), got_slot(0)};
  endfunction

  task automatic check_value(input string tag, input int v);
    logic [55:0] w;
    logic [13:0] ws;
    logic [13:0] gs;
    w = want_all(v);
    for (int k = 0; k < 4; k++) begin
      ws = w[k*14 +: 14];
      gs = got_slot(k);
      checks++;
      assert (gs === ws) else begin
        errors++;
        $error("FAIL %s v=%0d slot%0d got=%b want=%b",
               tag, v, k + 1, gs, ws);
      end
    end
  endtask

  task automatic apply(input string tag, input int v, input int wait_cyc);
    value = v[15:0];
    tick(wait_cyc);
    check_value(tag, v);
  endtask

  // Literal expectation for one slot, independent of the model.
  task automatic check_lit(input string tag, input int k,
                           input logic [13:0] ws);
    logic [13:0] gs;
    gs = got_slot(k);
    checks++;
    assert (gs === ws) else begin
      errors++;
      $error("FAIL %s slot%0d got=%b want=%b", tag, k + 1, gs, ws);
    end
  endtask

  logic [55:0] prev_pat;
  logic [55:0] new_pat;
  logic [55:0] obs;
  logic [13:0] dash;
  logic [13:0] eight;
  int          rv;

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    value   = 16'd350;
    dash    = {2{7'b0111111}};
    eight   = 14'd0;
    tick(3);
    for (int k = 0; k < 4; k++) check_lit("reset", k, eight);
    reset_n = 1'b1;
    apply("v350", 350, 50);
    check_lit("v350_lit", 0, {digit[0], digit[2]});
    check_lit("v350_lit", 2, {digit[0], digit[7]});
    apply("v210", 210, 50);
    apply("v30030", 30030, 50);
    apply("v85", 85, 50);
    apply("v115", 115, 50);
    apply("v11", 11, 50);
    apply("v125", 125, 50);
    apply("v1", 1, 50);
    apply("v0", 0, 50);
    apply("v202", 202, 50);
    check_lit("v202_dash", 1, dash);
    apply("v65521", 65521, 300);
    check_lit("v65521_dash", 0, dash);
    apply("v3", 3, 50);

    // Mid-computation change: no 210 result may ever appear.
    prev_pat = want_all(3);
    new_pat  = want_all(85);
    value    = 16'd210;
    for (int c = 0; c < 5; c++) begin
      tick(1);
      obs = got_all();
      checks++;
      assert (obs === prev_pat) else begin
        errors++;
        $error("FAIL chg_hold c=%0d got=%h want=%h", c, obs, prev_pat);
      end
    end
    value = 16'd85;
    for (int c = 0; c < 50; c++) begin
      tick(1);
      obs = got_all();
      checks++;
      assert (obs === prev_pat || obs === new_pat) else begin
        errors++;
        $error("FAIL chg_mid c=%0d got=%h want=%h", c, obs, new_pat);
      end
    end
    check_value("chg_final", 85);

    // Reset in the middle of computing 350.
    value = 16'd350;
    tick(4);
    reset_n = 1'b0;
    tick(2);
    for (int k = 0; k < 4; k++) check_lit("rst_held", k, eight);
    tick(5);
    for (int k = 0; k < 4; k++) check_lit("rst_held2", k, eight);
    reset_n = 1'b1;
    tick(50);
    check_value("rst_rel", 350);

    // Random values: small ones within the short budget.
    for (int r = 0; r < 8; r++) begin
      rv = $urandom_range(0, 350);
      apply("rand_small", rv, 50);
    end
    for (int r = 0; r < 8; r++) begin
      rv = $urandom_range(0, 65535);
      apply("rand_big", rv, 300);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
